car_warning: RTL and testbench

Vehicle safety-interlock monitor: raises `Warning` when the ignition is on while a door is open or the seat belt is unfastened. Sits between raw body-electronics switch inputs (asynchronous, bouncy) and the dashboard indicator/chime driver. It synchronizes and debounces each switch, then produces registered, glitch-free warning outputs.

---
 rtl/car_warning_pkg.sv | 17 +
 rtl/car_warning_debounce.sv | 35 +++
 rtl/car_warning.sv | 64 ++++++
 tb/tb_car_warning.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/car_warning_pkg.sv
// car_warning_pkg: safe switch levels, default parameters and cause bit layout
package car_warning_pkg;
  localparam logic DOOR_SAFE = 1'b1;
  localparam logic IGN_SAFE = 1'b0;
  localparam logic BELT_SAFE = 1'b1;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CHIME_PERIOD = 8;
  localparam int CAUSE_DOOR = 1;
  localparam int CAUSE_BELT = 0;
  typedef logic [1:0] cause_t;
  function automatic cause_t warn_cause(input logic door, input logic ign, input logic belt);
    warn_cause = '0;
    warn_cause[CAUSE_DOOR] = ign & ~door;
    warn_cause[CAUSE_BELT] = ign & ~belt;
  endfunction
endpackage

// File: rtl/car_warning_debounce.sv
// car_warning_debounce: synchronizer chain plus run-length debouncer for one switch
module car_warning_debounce
  import car_warning_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic synced;
  logic hit;
  assign synced = sync[SYNC_STAGES-1];
  assign hit = int'(cnt) + 1 == DEBOUNCE_CYCLES;
  // metastability chain, preloaded with the safe level so reset looks like a settled switch
  always_ff @(posedge clk)
    if (rst) sync <= {SYNC_STAGES{RESET_VAL}};
    else sync <= {sync[SYNC_STAGES-2:0], sw};
  // accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      level <= RESET_VAL;
    end else if (synced == level) cnt <= '0;
    else if (hit) begin
      level <= synced;
      cnt <= '0;
    end else cnt <= cnt + CW'(1);
endmodule

// File: rtl/car_warning.sv
// car_warning: ignition interlock warning from debounced door/ignition/belt switches
// optional chime drive enabled by defining CAR_WARNING_CHIME_EN
module car_warning
  import car_warning_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef CAR_WARNING_CHIME_EN
  , parameter int CHIME_PERIOD = DEF_CHIME_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic DoorClose,
  input  logic Ignition,
  input  logic SeatBelt,
  output logic Warning,
  output logic [1:0] WarnCause
`ifdef CAR_WARNING_CHIME_EN
  , output logic Chime
`endif
);
  logic deb_door, deb_ign, deb_belt;
  cause_t cause_nxt;
  logic warn_nxt;
  car_warning_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(DOOR_SAFE))
    u_door (.clk(clk), .rst(rst), .sw(DoorClose), .level(deb_door));
  car_warning_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(IGN_SAFE))
    u_ign (.clk(clk), .rst(rst), .sw(Ignition), .level(deb_ign));
  car_warning_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(BELT_SAFE))
    u_belt (.clk(clk), .rst(rst), .sw(SeatBelt), .level(deb_belt));
  // combine accepted switch levels into the next cause vector
  always_comb begin
    cause_nxt = warn_cause(deb_door, deb_ign, deb_belt);
    warn_nxt = |cause_nxt;
  end
  // register outputs so the dashboard never sees combinational glitches
  always_ff @(posedge clk)
    if (rst) begin
      WarnCause <= '0;
      Warning <= 1'b0;
    end else begin
      WarnCause <= cause_nxt;
      Warning <= warn_nxt;
    end
`ifdef CAR_WARNING_CHIME_EN
  localparam int PW = $clog2(CHIME_PERIOD + 1);
  logic [PW-1:0] ccnt;
  logic last;
  assign last = int'(ccnt) == CHIME_PERIOD - 1;
  // chime tracks the next Warning value so it rises and falls on the same edge as Warning
  always_ff @(posedge clk)
    if (rst || !warn_nxt) begin
      Chime <= 1'b0;
      ccnt <= '0;
    end else if (!Warning) begin
      Chime <= 1'b1;
      ccnt <= '0;
    end else begin
      Chime <= last ? ~Chime : Chime;
      ccnt <= last ? '0 : ccnt + PW'(1);
    end
`endif
endmodule

// File: tb/tb_car_warning.sv
// tb_car_warning: model-checked directed bench for car_warning (chime checks under CAR_WARNING_CHIME_EN)
module tb_car_warning;
  localparam int S = 2;
  localparam int DC = 4;
  localparam int CP = 8;
  logic clk, rst, door, ign, belt;
  logic Warning;
  logic [1:0] WarnCause;
  logic chime;
  int nvec = 0;
  int errs = 0;
  car_warning dut (
    .clk(clk), .rst(rst), .DoorClose(door), .Ignition(ign), .SeatBelt(belt),
    .Warning(Warning), .WarnCause(WarnCause)
`ifdef CAR_WARNING_CHIME_EN
    , .Chime(chime)
`endif
  );
`ifndef CAR_WARNING_CHIME_EN
  assign chime = 1'b0;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] e);
    nvec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // model: raw sample history, window of synchronized values, accepted levels
  logic [2:0] raw, dm;
  logic [31:0] rawh[3];
  logic [31:0] win[3];
  int n[3];
  logic [1:0] exp_c, c_n;
  logic exp_w, exp_ch, w_n, sb, armed = 1'b0;
  int age;
  localparam logic [2:0] SAFE = 3'b101;
  assign raw = {belt, ign, door};
  always @(posedge clk) begin
    c_n = {dm[1] & ~dm[0], dm[1] & ~dm[2]};
    w_n = |c_n;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        rawh[c] = {32{SAFE[c]}};
        win[c] = '0;
        n[c] = 0;
      end
      dm = SAFE;
      exp_c = 2'b00;
      exp_w = 1'b0;
      exp_ch = 1'b0;
      age = 0;
      armed = 1'b1;
    end else if (armed) begin
      age = w_n ? (exp_w ? age + 1 : 0) : 0;
      exp_ch = w_n && ((age / CP) % 2 == 0);
      exp_c = c_n;
      exp_w = w_n;
      for (int c = 0; c < 3; c++) begin
        sb = rawh[c][S-1];
        rawh[c] = {rawh[c][30:0], raw[c]};
        win[c] = {win[c][30:0], sb};
        if (n[c] < DC) n[c]++;
        if (n[c] >= DC && win[c][DC-1:0] == {DC{~dm[c]}}) dm[c] = ~dm[c];
      end
    end
  end

  // compare every cycle once the first reset has been seen
  always @(negedge clk)
    if (armed) begin
      chk("model_warning", {1'b0, Warning}, {1'b0, exp_w});
      chk("model_cause", WarnCause, exp_c);
`ifdef CAR_WARNING_CHIME_EN
      chk("model_chime", {1'b0, chime}, {1'b0, exp_ch});
`endif
    end

  task automatic step(input logic d, input logic i, input logic b, input logic ew,
                      input logic [1:0] ec, input logic pw, input logic [1:0] pc);
    @(negedge clk);
    door = d; ign = i; belt = b;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_warning", {1'b0, Warning}, {1'b0, pw});
    chk("pre_cause", WarnCause, pc);
    @(posedge clk);
    #1;
    chk("lat7_warning", {1'b0, Warning}, {1'b0, ew});
    chk("lat7_cause", WarnCause, ec);
    repeat (13) @(posedge clk);
  endtask

  logic seen;
  initial begin
    rst = 1'b1; door = 1'b1; ign = 1'b0; belt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_warning", {1'b0, Warning}, 2'd0);
    chk("reset_cause", WarnCause, 2'b00);
    chk("reset_chime", {1'b0, chime}, 2'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("ign_off_warning", {1'b0, Warning}, 2'd0);
    chk("ign_off_cause", WarnCause, 2'b00);
    step(0, 0, 0, 0, 2'b00, 0, 2'b00);
    step(0, 1, 0, 1, 2'b11, 0, 2'b00);
    step(1, 1, 0, 1, 2'b01, 1, 2'b11);
    step(1, 1, 1, 0, 2'b00, 1, 2'b01);
    step(1, 0, 0, 0, 2'b00, 0, 2'b00);
    @(negedge clk); ign = 1'b1;
    repeat (3) @(negedge clk);
    ign = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; seen |= Warning; end
    chk("pulse3_rejected", {1'b0, seen}, 2'd0);
    @(negedge clk); ign = 1'b1;
    repeat (4) @(negedge clk);
    ign = 1'b0;
    seen = 1'b0;
    repeat (15) begin @(posedge clk); #1; seen |= Warning; end
    chk("pulse4_accepted", {1'b0, seen}, 2'd1);
    repeat (10) @(posedge clk);
    step(0, 1, 0, 1, 2'b11, 0, 2'b00);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_warning", {1'b0, Warning}, 2'd0);
    chk("midrst_cause", WarnCause, 2'b00);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rerun6_warning", {1'b0, Warning}, 2'd0);
    @(posedge clk); #1;
    chk("rerun7_warning", {1'b0, Warning}, 2'd1);
    chk("rerun7_cause", WarnCause, 2'b11);
    repeat (10) @(posedge clk);
    @(negedge clk); belt = 1'b1;
    seen = 1'b1;
    repeat (20) begin @(posedge clk); #1; seen &= Warning; end
    chk("belt_no_dropout", {1'b0, seen}, 2'd1);
    chk("belt_cause", WarnCause, 2'b10);
`ifdef CAR_WARNING_CHIME_EN
    step(1, 0, 1, 0, 2'b00, 1, 2'b10);
    @(negedge clk); door = 1'b0; ign = 1'b1;
    repeat (6) @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("chime_pattern", {1'b0, chime}, {1'b0, (k / 8) % 2 == 0});
    end
    @(negedge clk); ign = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("chime_pre_warning", {1'b0, Warning}, 2'd1);
    @(posedge clk); #1;
    chk("chime_off_warning", {1'b0, Warning}, 2'd0);
    chk("chime_off_chime", {1'b0, chime}, 2'd0);
`endif
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
